// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use detection.
module id_ex_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iStall,
  input  logic                  iFlush,
  input  logic                  iValid,
  input  logic [OP_WIDTH-1:0]   iALUControl,
  input  logic [DATA_WIDTH-1:0] iRD1,
  input  logic [DATA_WIDTH-1:0] iRD2,
  input  logic [DATA_WIDTH-1:0] iImmExt,
  input  logic [DATA_WIDTH-1:0] iPC,
  input  logic                  iALUSrcA,
  input  logic                  iALUSrcB,
  input  logic [4:0]            iRs1,
  input  logic [4:0]            iRs2,
  input  logic [4:0]            iRd,
  input  logic                  iRegWrite,
  input  logic                  iMemWrite,
  input  logic [1:0]            iResultSrc,
  input  logic [4:0]            iMemRd,
  input  logic [4:0]            iWbRd,
  input  logic                  iMemRegWrite,
  input  logic                  iWbRegWrite,
  input  logic [DATA_WIDTH-1:0] iMemALUResult,
  input  logic [DATA_WIDTH-1:0] iWbResult,
  output logic                  oValid,
  output logic [OP_WIDTH-1:0]   oALUControl,
  output logic [DATA_WIDTH-1:0] oSrcA,
  output logic [DATA_WIDTH-1:0] oSrcB,
  output logic [DATA_WIDTH-1:0] oStoreData,
  output logic [DATA_WIDTH-1:0] oPC,
  output logic [4:0]            oRd,
  output logic                  oRegWrite,
  output logic                  oMemWrite,
  output logic [1:0]            oResultSrc,
  output logic                  oLoadUse
);

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  logic                  alu_src_a_q;
  logic                  alu_src_b_q;
  logic [DATA_WIDTH-1:0] rd1_q;
  logic [DATA_WIDTH-1:0] rd2_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [4:0]            rs1_q;
  logic [4:0]            rs2_q;
  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;

  // EX register: reset > flush (bubble) > stall (hold) > capture.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      oValid      <= 1'b0;
      oRegWrite   <= 1'b0;
      oMemWrite   <= 1'b0;
      oResultSrc  <= 2'b00;
      oRd         <= 5'd0;
      oALUControl <= '0;
      oPC         <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      alu_src_a_q <= 1'b0;
      alu_src_b_q <= 1'b0;
    end else if (iFlush) begin
      oValid    <= 1'b0;
      oRegWrite <= 1'b0;
      oMemWrite <= 1'b0;
    end else if (!iStall) begin
      oValid      <= iValid;
      oRegWrite   <= iRegWrite & iValid;
      oMemWrite   <= iMemWrite & iValid;
      oResultSrc  <= iResultSrc;
      oRd         <= iRd;
      oALUControl <= iALUControl;
      oPC         <= iPC;
      rd1_q       <= iRD1;
      rd2_q       <= iRD2;
      imm_q       <= iImmExt;
      rs1_q       <= iRs1;
      rs2_q       <= iRs2;
      alu_src_a_q <= iALUSrcA;
      alu_src_b_q <= iALUSrcB;
    end
  end

  // Forwarding muxes: MEM result wins over WB result; x0 is never forwarded.
  always_comb begin
    fwd_a = rd1_q;
    fwd_b = rd2_q;
    if (iMemRegWrite && (iMemRd != 5'd0) && (iMemRd == rs1_q)) begin
      fwd_a = iMemALUResult;
    end else if (iWbRegWrite && (iWbRd != 5'd0) && (iWbRd == rs1_q)) begin
      fwd_a = iWbResult;
    end
    if (iMemRegWrite && (iMemRd != 5'd0) && (iMemRd == rs2_q)) begin
      fwd_b = iMemALUResult;
    end else if (iWbRegWrite && (iWbRd != 5'd0) && (iWbRd == rs2_q)) begin
      fwd_b = iWbResult;
    end
  end

  // Operand selection and load-use hazard detection against the decode indices.
  always_comb begin
    oSrcA      = alu_src_a_q ? oPC : fwd_a;
    oSrcB      = alu_src_b_q ? imm_q : fwd_b;
    oStoreData = fwd_b;
    oLoadUse   = oValid && (oResultSrc == RESULT_LOAD) && (oRd != 5'd0) &&
                 ((oRd == iRs1) || (oRd == iRs2));
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a transaction-level model of the EX slot.
module tb_id_ex_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 4;

  logic          iClk = 1'b0;
  logic          iRstN, iStall, iFlush, iValid;
  logic [OW-1:0] iALUControl;
  logic [DW-1:0] iRD1, iRD2, iImmExt, iPC;
  logic          iALUSrcA, iALUSrcB;
  logic [4:0]    iRs1, iRs2, iRd;
  logic          iRegWrite, iMemWrite;
  logic [1:0]    iResultSrc;
  logic [4:0]    iMemRd, iWbRd;
  logic          iMemRegWrite, iWbRegWrite;
  logic [DW-1:0] iMemALUResult, iWbResult;
  logic          oValid;
  logic [OW-1:0] oALUControl;
  logic [DW-1:0] oSrcA, oSrcB, oStoreData, oPC;
  logic [4:0]    oRd;
  logic          oRegWrite, oMemWrite;
  logic [1:0]    oResultSrc;
  logic          oLoadUse;

  id_ex_stage #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .iClk(iClk), .iRstN(iRstN), .iStall(iStall), .iFlush(iFlush), .iValid(iValid),
    .iALUControl(iALUControl), .iRD1(iRD1), .iRD2(iRD2), .iImmExt(iImmExt), .iPC(iPC),
    .iALUSrcA(iALUSrcA), .iALUSrcB(iALUSrcB), .iRs1(iRs1), .iRs2(iRs2), .iRd(iRd),
    .iRegWrite(iRegWrite), .iMemWrite(iMemWrite), .iResultSrc(iResultSrc),
    .iMemRd(iMemRd), .iWbRd(iWbRd), .iMemRegWrite(iMemRegWrite), .iWbRegWrite(iWbRegWrite),
    .iMemALUResult(iMemALUResult), .iWbResult(iWbResult),
    .oValid(oValid), .oALUControl(oALUControl), .oSrcA(oSrcA), .oSrcB(oSrcB),
    .oStoreData(oStoreData), .oPC(oPC), .oRd(oRd), .oRegWrite(oRegWrite),
    .oMemWrite(oMemWrite), .oResultSrc(oResultSrc), .oLoadUse(oLoadUse)
  );

  always #5 iClk = ~iClk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the instruction sitting in EX; 'known' marks whether payload fields are defined.
  typedef struct {
    logic          valid, rw, mw, sa, sb;
    logic [1:0]    rsrc;
    logic [4:0]    rd, rs1, rs2;
    logic [OW-1:0] alu;
    logic [DW-1:0] pc, rd1, rd2, imm;
  } ex_t;
  ex_t m;
  bit  m_known = 0;
  bit  m_init  = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] fwd(input logic [4:0] idx, input logic [DW-1:0] rf);
    if (iMemRegWrite && iMemRd != 0 && iMemRd == idx) return iMemALUResult;
    if (iWbRegWrite && iWbRd != 0 && iWbRd == idx) return iWbResult;
    return rf;
  endfunction

  task automatic check_outputs();
    logic lu;
    if (!m_init) return;
    lu = m.valid && m.rsrc == 2'b01 && m.rd != 0 && (m.rd == iRs1 || m.rd == iRs2);
    check("valid", DW'(oValid), DW'(m.valid));
    check("regwrite", DW'(oRegWrite), DW'(m.valid & m.rw));
    check("memwrite", DW'(oMemWrite), DW'(m.valid & m.mw));
    check("loaduse", DW'(oLoadUse), DW'(lu));
    if (m_known) begin
      check("alu", DW'(oALUControl), DW'(m.alu));
      check("pc", oPC, m.pc);
      check("rd", DW'(oRd), DW'(m.rd));
      check("rsrc", DW'(oResultSrc), DW'(m.rsrc));
      check("srca", oSrcA, m.sa ? m.pc : fwd(m.rs1, m.rd1));
      check("srcb", oSrcB, m.sb ? m.imm : fwd(m.rs2, m.rd2));
      check("store", oStoreData, fwd(m.rs2, m.rd2));
    end
  endtask

  // Check current outputs, clock once, then advance the model with the sampled inputs.
  task automatic run_cycle();
    #1;
    check_outputs();
    @(posedge iClk);
    if (!iRstN) begin
      m = '{valid: 0, rw: 0, mw: 0, sa: 0, sb: 0, rsrc: 0, rd: 0, rs1: 0, rs2: 0,
            alu: 0, pc: 0, rd1: 0, rd2: 0, imm: 0};
      m_known = 1;
      m_init  = 1;
    end else if (iFlush) begin
      m.valid = 0;
      m_known = 0;
    end else if (!iStall) begin
      m = '{valid: iValid, rw: iRegWrite, mw: iMemWrite, sa: iALUSrcA, sb: iALUSrcB,
            rsrc: iResultSrc, rd: iRd, rs1: iRs1, rs2: iRs2, alu: iALUControl,
            pc: iPC, rd1: iRD1, rd2: iRD2, imm: iImmExt};
      m_known = iValid;
    end
    @(negedge iClk);
  endtask

  task automatic idle_inputs();
    iRstN = 1; iStall = 0; iFlush = 0; iValid = 0; iALUControl = 0;
    iRD1 = 0; iRD2 = 0; iImmExt = 0; iPC = 0; iALUSrcA = 0; iALUSrcB = 0;
    iRs1 = 0; iRs2 = 0; iRd = 0; iRegWrite = 0; iMemWrite = 0; iResultSrc = 0;
    iMemRd = 0; iWbRd = 0; iMemRegWrite = 0; iWbRegWrite = 0;
    iMemALUResult = 0; iWbResult = 0;
  endtask

  task automatic random_inputs();
    iRstN = ($urandom_range(0, 59) != 0);
    iStall = ($urandom_range(0, 3) == 0);
    iFlush = ($urandom_range(0, 9) == 0);
    iValid = ($urandom_range(0, 4) != 0);
    iALUControl = OW'($urandom);
    iRD1 = $urandom; iRD2 = $urandom; iImmExt = $urandom; iPC = $urandom;
    iALUSrcA = 1'($urandom); iALUSrcB = 1'($urandom);
    iRs1 = 5'($urandom_range(0, 7)); iRs2 = 5'($urandom_range(0, 7));
    iRd = 5'($urandom_range(0, 7));
    iRegWrite = 1'($urandom); iMemWrite = 1'($urandom);
    iResultSrc = 2'($urandom_range(0, 2));
    iMemRd = 5'($urandom_range(0, 7)); iWbRd = 5'($urandom_range(0, 7));
    iMemRegWrite = 1'($urandom); iWbRegWrite = 1'($urandom);
    iMemALUResult = $urandom; iWbResult = $urandom;
  endtask

  initial begin
    idle_inputs();
    iRstN = 0;
    @(negedge iClk);
    run_cycle();
    // Reset state with forwarding disabled.
    check("rst_srca", oSrcA, 0);
    check("rst_srcb", oSrcB, 0);
    check("rst_store", oStoreData, 0);
    check("rst_lu", DW'(oLoadUse), 0);
    iRstN = 1;

    // Simple capture with immediate operand.
    iValid = 1; iRs1 = 5; iRD1 = 32'h10; iALUSrcB = 1; iImmExt = 32'h4;
    run_cycle();
    check("cap_valid", DW'(oValid), 1);
    check("cap_srca", oSrcA, 32'h10);
    check("cap_srcb", oSrcB, 32'h4);

    // MEM forwarding beats WB, WB used once MEM drops out.
    iRs1 = 3; iRD1 = 32'h11; iALUSrcB = 0;
    run_cycle();
    iMemRd = 3; iMemRegWrite = 1; iMemALUResult = 32'hAA;
    iWbRd = 3; iWbRegWrite = 1; iWbResult = 32'hBB;
    #1 check("fwd_mem", oSrcA, 32'hAA);
    iMemRegWrite = 0;
    #1 check("fwd_wb", oSrcA, 32'hBB);
    run_cycle();

    // x0 is never forwarded.
    idle_inputs();
    iValid = 1; iRs2 = 0; iRD2 = 0;
    run_cycle();
    iMemRd = 0; iMemRegWrite = 1; iMemALUResult = 32'h55;
    #1 check("x0_srcb", oSrcB, 0);
    check("x0_store", oStoreData, 0);
    run_cycle();

    // Load-use hazard holds across a stall.
    idle_inputs();
    iValid = 1; iResultSrc = 2'b01; iRd = 7; iRegWrite = 1;
    run_cycle();
    iRs1 = 1; iRs2 = 7; iRd = 2; iResultSrc = 0;
    #1 check("lu_set", DW'(oLoadUse), 1);
    iStall = 1;
    run_cycle();
    check("lu_held", DW'(oLoadUse), 1);
    check("lu_rd", DW'(oRd), 7);

    // Flush wins over stall on a valid store.
    idle_inputs();
    iValid = 1; iMemWrite = 1;
    run_cycle();
    iFlush = 1; iStall = 1;
    run_cycle();
    check("fl_valid", DW'(oValid), 0);
    check("fl_mw", DW'(oMemWrite), 0);
    check("fl_rw", DW'(oRegWrite), 0);

    // Reset wins over stall with a valid instruction in EX.
    idle_inputs();
    iValid = 1; iRegWrite = 1; iPC = 32'h1234; iRd = 9; iRD1 = 32'hDEAD;
    run_cycle();
    iRstN = 0; iStall = 1;
    run_cycle();
    check("mr_valid", DW'(oValid), 0);
    check("mr_pc", oPC, 0);
    check("mr_rd", DW'(oRd), 0);
    check("mr_srca", oSrcA, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      run_cycle();
    end
    idle_inputs();
    run_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
